// File: rtl/sidisk_ctrl_if.sv
// ---------------------------------------------------------------------------
// sidisk_ctrl_if
// Bundles the CPU-side IO register window and the SRAM-side port of the
// RAM-disk controller.
//   io_sel/io_wr/io_rd/io_adr/io_wdata : IO register access from the CPU decode
//   io_rdata                           : register read data (combinational)
//   mem_busy                           : mapper currently owns the SRAM
//   sram_en/sram_we/sram_adr/sram_wdata: SRAM request driven by the controller
//   sram_rdata                         : SRAM read data
//   busy                               : controller has an access pending
// Modports: slave = the controller, master = the surrounding system.
// ---------------------------------------------------------------------------
interface sidisk_ctrl_if #(
  parameter int ADR_W = 19
);
  logic             io_sel;
  logic             io_wr;
  logic             io_rd;
  logic [2:0]       io_adr;
  logic [7:0]       io_wdata;
  logic [7:0]       io_rdata;
  logic             mem_busy;
  logic             sram_en;
  logic             sram_we;
  logic [ADR_W-1:0] sram_adr;
  logic [7:0]       sram_wdata;
  logic [7:0]       sram_rdata;
  logic             busy;

  modport slave (
    input  io_sel, io_wr, io_rd, io_adr, io_wdata, mem_busy, sram_rdata,
    output io_rdata, sram_en, sram_we, sram_adr, sram_wdata, busy
  );

  modport master (
    output io_sel, io_wr, io_rd, io_adr, io_wdata, mem_busy, sram_rdata,
    input  io_rdata, sram_en, sram_we, sram_adr, sram_wdata, busy
  );
endinterface

// File: rtl/sidisk_ctrl.sv
// ---------------------------------------------------------------------------
// sidisk_ctrl
// IO-mapped RAM-disk controller for the expansion SRAM. The CPU reaches every
// SRAM byte through a small register window with an auto-incrementing
// pointer. SRAM cycles are slotted into gaps where the mapper does not own
// the SRAM; the CPU always wins and pre-empts an access in progress.
//
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : sidisk_ctrl_if.slave (IO window, SRAM port, busy flag)
//
// Register map (io_adr):
//   0 ADR_L  pointer[7:0]
//   1 ADR_M  pointer[15:8]
//   2 ADR_H  pointer[ADR_W-1:16], unused upper bits read 0
//   3 DATA   read: prefetched byte, write: byte to store at pointer
//   4 STATUS {5'b0, rdbuf_valid, overrun, busy}
//   5-7      read 0x00, writes ignored
// ---------------------------------------------------------------------------
module sidisk_ctrl #(
  parameter int ADR_W      = 19,
  parameter int ACC_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  sidisk_ctrl_if.slave bus
);

  localparam logic [2:0] REG_ADR_L  = 3'd0;
  localparam logic [2:0] REG_ADR_M  = 3'd1;
  localparam logic [2:0] REG_ADR_H  = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    ACCESS    = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  state_t           state_reg;
  state_t           state_next;
  op_t              op_reg;
  logic [3:0]       cnt_reg;
  logic [ADR_W-1:0] ptr_reg;
  logic [ADR_W-1:0] ptr_wr;
  logic [ADR_W-1:0] ptr_inc;
  logic [23:0]      ptr_pad;
  logic [7:0]       wdata_reg;
  logic [7:0]       rdbuf_reg;
  logic             rdbuf_valid_reg;
  logic             overrun_reg;

  logic             wr_ev;
  logic             rd_ev;
  logic             data_wr;
  logic             adr_wr;
  logic             data_rd;
  logic             stat_rd;
  logic             host_req;
  logic             accept;
  logic             reject;
  logic             slot_free;
  logic             acc_done;
  logic             busy_int;
  logic             sram_en_int;
  logic             sram_we_int;
  logic [7:0]       rdata;

  // -------------------------------------------------------------------------
  // Host decode. A write strobe shadows a simultaneous read strobe.
  // -------------------------------------------------------------------------
  assign wr_ev    = bus.io_sel & bus.io_wr;
  assign rd_ev    = bus.io_sel & bus.io_rd & ~bus.io_wr;
  assign data_wr  = wr_ev & (bus.io_adr == REG_DATA);
  assign adr_wr   = wr_ev & (bus.io_adr <= REG_ADR_H);
  assign data_rd  = rd_ev & (bus.io_adr == REG_DATA);
  assign stat_rd  = rd_ev & (bus.io_adr == REG_STATUS);

  // Pointer/data accesses are only taken while idle; anything arriving
  // during an access is dropped and flagged as an overrun.
  assign host_req = data_wr | adr_wr | data_rd;
  assign busy_int = (state_reg != IDLE);
  assign accept   = host_req & ~busy_int;
  assign reject   = host_req & busy_int;

  assign slot_free = ~bus.mem_busy;
  assign acc_done  = (state_reg == ACCESS) & slot_free & (cnt_reg == 4'd0);

  assign ptr_inc = ptr_reg + ADR_W'(1);
  assign ptr_pad = 24'(ptr_reg);

  // Pointer value after an ADR_x write: only the addressed byte changes.
  always_comb begin
    ptr_wr = ptr_reg;
    case (bus.io_adr)
      REG_ADR_L: ptr_wr[7:0]        = bus.io_wdata;
      REG_ADR_M: ptr_wr[15:8]       = bus.io_wdata;
      REG_ADR_H: ptr_wr[ADR_W-1:16] = bus.io_wdata[ADR_W-17:0];
      default:   ptr_wr             = ptr_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (slot_free) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!slot_free) begin
          // CPU pre-empts: drop the access and start over with a full count.
          state_next = WAIT_SLOT;
        end else if (cnt_reg == 4'd0) begin
          // A completed write always chains into a prefetch of the next byte.
          state_next = (op_reg == OP_WR) ? WAIT_SLOT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Enable follows mem_busy combinationally so the SRAM is
  // released in the very cycle the mapper claims it.
  // -------------------------------------------------------------------------
  always_comb begin
    sram_en_int = 1'b0;
    sram_we_int = 1'b0;
    if ((state_reg == ACCESS) && slot_free) begin
      sram_en_int = 1'b1;
      sram_we_int = (op_reg == OP_WR);
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg          <= OP_RD;
      cnt_reg         <= 4'd0;
      ptr_reg         <= '0;
      wdata_reg       <= 8'h00;
      rdbuf_reg       <= 8'h00;
      rdbuf_valid_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      // Access length counter
      if ((state_reg == WAIT_SLOT) && slot_free) begin
        cnt_reg <= CNT_LOAD;
      end else if ((state_reg == ACCESS) && slot_free && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      // Operation select
      if (accept) begin
        op_reg <= data_wr ? OP_WR : OP_RD;
      end else if (acc_done && (op_reg == OP_WR)) begin
        op_reg <= OP_RD;
      end

      if (accept && data_wr) begin
        wdata_reg <= bus.io_wdata;
      end

      // Pointer: ADR_x writes load a byte; DATA reads and completed writes
      // step it. Wraps naturally at 2^ADR_W.
      if (accept && adr_wr) begin
        ptr_reg <= ptr_wr;
      end else if (accept && data_rd) begin
        ptr_reg <= ptr_inc;
      end else if (acc_done && (op_reg == OP_WR)) begin
        ptr_reg <= ptr_inc;
      end

      // Read buffer: any accepted access invalidates it until the
      // follow-up prefetch lands.
      if (acc_done && (op_reg == OP_RD)) begin
        rdbuf_reg       <= bus.sram_rdata;
        rdbuf_valid_reg <= 1'b1;
      end else if (accept) begin
        rdbuf_valid_reg <= 1'b0;
      end

      // Sticky overrun, cleared by a STATUS read; a set takes precedence.
      if (reject) begin
        overrun_reg <= 1'b1;
      end else if (stat_rd) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register read mux
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = 8'h00;
    case (bus.io_adr)
      REG_ADR_L:  rdata = ptr_pad[7:0];
      REG_ADR_M:  rdata = ptr_pad[15:8];
      REG_ADR_H:  rdata = ptr_pad[23:16];
      REG_DATA:   rdata = rdbuf_reg;
      REG_STATUS: rdata = {5'b00000, rdbuf_valid_reg, overrun_reg, busy_int};
      default:    rdata = 8'h00;
    endcase
  end

  assign bus.io_rdata   = rdata;
  assign bus.sram_en    = sram_en_int;
  assign bus.sram_we    = sram_we_int;
  assign bus.sram_adr   = ptr_reg;
  assign bus.sram_wdata = wdata_reg;
  assign bus.busy       = busy_int;

endmodule

// File: tb/tb_sidisk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sidisk_ctrl
// Self-checking bench for sidisk_ctrl. A byte-level SRAM device model sits on
// the SRAM port (a write lands only after ACC_CYCLES uninterrupted enable
// cycles). A transaction-level reference model tracks pointer, read buffer,
// flags and expected memory contents; directed scenarios are followed by
// randomized host traffic with random mapper contention.
// ---------------------------------------------------------------------------
module tb_sidisk_ctrl;
  localparam int ADR_W  = 19;
  localparam int ACC    = 2;
  localparam int MEM_SZ = 1 << ADR_W;
  localparam int PMASK  = MEM_SZ - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sidisk_ctrl_if #(.ADR_W(ADR_W)) bus ();

  sidisk_ctrl #(.ADR_W(ADR_W), .ACC_CYCLES(ACC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // SRAM device model (unwritten locations hold a fixed pattern)
  // -------------------------------------------------------------------------
  function automatic logic [7:0] pat(input int a);
    return 8'((a * 131) ^ (a >>> 9) ^ 32'h3C);
  endfunction

  logic [7:0] wmem [int];
  int   run_len   = 0;
  int   run_adr   = 0;
  logic run_we    = 1'b0;
  int   last_len  = 0;
  int   last_adr  = -1;
  logic last_we   = 1'b0;
  int   n_commits = 0;

  function automatic logic [7:0] sram_peek(input int a);
    return wmem.exists(a) ? wmem[a] : pat(a);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else if (bus.sram_en) begin
      if (run_len == 0) begin
        run_adr = int'(bus.sram_adr);
        run_we  = bus.sram_we;
      end
      run_len++;
      if (bus.sram_we && run_len == ACC) begin
        wmem[int'(bus.sram_adr)] = bus.sram_wdata;
        n_commits++;
      end
      last_len = run_len;
      last_adr = run_adr;
      last_we  = run_we;
    end else begin
      run_len = 0;
    end
    bus.sram_rdata = sram_peek(int'(bus.sram_adr));
  end

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int         m_ptr;
  logic [7:0] m_rdbuf;
  logic       m_valid;
  logic       m_overrun;
  logic       m_busy;
  int         m_commits;
  logic [7:0] exp_wr [int];

  function automatic logic [7:0] exp_rd(input int a);
    return exp_wr.exists(a) ? exp_wr[a] : pat(a);
  endfunction

  task automatic model_reset();
    m_ptr     = 0;
    m_rdbuf   = 8'h00;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_busy    = 1'b0;
  endtask

  function automatic logic [7:0] exp_reg(input int k);
    case (k)
      0:       return 8'(m_ptr);
      1:       return 8'(m_ptr >> 8);
      2:       return 8'(m_ptr >> 16);
      default: return 8'h00;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Bus helpers (entered and left 1 time unit after a rising edge)
  // -------------------------------------------------------------------------
  task automatic io_cycle(input logic wr, input logic rd, input logic [2:0] adr,
                          input logic [7:0] wd, output logic [7:0] rv);
    bus.io_sel   = 1'b1;
    bus.io_wr    = wr;
    bus.io_rd    = rd;
    bus.io_adr   = adr;
    bus.io_wdata = wd;
    #3 rv = bus.io_rdata;
    @(posedge clk);
    #1;
    bus.io_sel = 1'b0;
    bus.io_wr  = 1'b0;
    bus.io_rd  = 1'b0;
  endtask

  // kind: 0 ADR_x write, 1 DATA write, 2 DATA read, 3 STATUS read,
  //       4 plain register read, 5 DATA write with read strobe also high
  task automatic do_op(input int kind, input int k, input logic [7:0] v);
    logic [7:0] rv;
    case (kind)
      0: begin
        io_cycle(1'b1, 1'b0, 3'(k), v, rv);
        if (m_busy) m_overrun = 1'b1;
        else begin
          case (k)
            0:       m_ptr = (m_ptr & 32'h7FF00) | int'(v);
            1:       m_ptr = (m_ptr & 32'h700FF) | (int'(v) << 8);
            default: m_ptr = (m_ptr & 32'h0FFFF) | ((int'(v) << 16) & PMASK);
          endcase
          m_valid = 1'b0;
          m_busy  = 1'b1;
        end
      end
      1, 5: begin
        io_cycle(1'b1, kind == 5, 3'd3, v, rv);
        if (kind == 5) check("wr_rd_rdata", rv, m_rdbuf);
        if (m_busy) m_overrun = 1'b1;
        else begin
          exp_wr[m_ptr] = v;
          m_ptr   = (m_ptr + 1) & PMASK;
          m_valid = 1'b0;
          m_busy  = 1'b1;
          m_commits++;
        end
      end
      2: begin
        io_cycle(1'b0, 1'b1, 3'd3, 8'h00, rv);
        check("data_rd", rv, m_rdbuf);
        if (m_busy) m_overrun = 1'b1;
        else begin
          m_ptr   = (m_ptr + 1) & PMASK;
          m_valid = 1'b0;
          m_busy  = 1'b1;
        end
      end
      3: begin
        io_cycle(1'b0, 1'b1, 3'd4, 8'h00, rv);
        check("status", rv, {29'd0, m_valid, m_overrun, m_busy});
        m_overrun = 1'b0;
      end
      default: begin
        io_cycle(1'b0, 1'b1, 3'(k), 8'h00, rv);
        check("reg_rd", rv, exp_reg(k));
      end
    endcase
    $display("txn kind=%0d reg=%0d wdata=%02h rdata=%02h ptr=%05h", kind, k, v, rv, m_ptr);
  endtask

  // Wait for the controller to go idle, optionally with random mapper
  // contention, then retire the outstanding prefetch in the model.
  task automatic settle(input bit rnd);
    for (int i = 0; i < 400 && bus.busy; i++) begin
      bus.mem_busy = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk);
      #1;
    end
    bus.mem_busy = 1'b0;
    check("idle_timeout", {31'd0, bus.busy}, 32'd0);
    if (m_busy) begin
      m_busy  = 1'b0;
      m_valid = 1'b1;
      m_rdbuf = exp_rd(m_ptr);
      check("run_len", last_len, ACC);
      check("prefetch_adr", last_adr, m_ptr);
      check("prefetch_we", {31'd0, last_we}, 32'd0);
      check("commits", n_commits, m_commits);
    end
  endtask

  task automatic wait_en();
    for (int i = 0; i < 20 && !bus.sram_en; i++) begin
      @(posedge clk);
      #1;
    end
    check("en_seen", {31'd0, bus.sram_en}, 32'd1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    bus.io_sel   = 1'b0;
    bus.io_wr    = 1'b0;
    bus.io_rd    = 1'b0;
    bus.io_adr   = 3'd0;
    bus.io_wdata = 8'h00;
    bus.mem_busy = 1'b0;
    model_reset();
    m_commits = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state
    check("rst_en", {31'd0, bus.sram_en}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k != 3 && k != 4) do_op(4, k, 8'h00);
    end
    do_op(3, 4, 8'h00);
    do_op(2, 3, 8'h00);
    settle(1'b0);

    // 2: pointer load and prefetch
    do_op(0, 0, 8'h34); settle(1'b0);
    do_op(0, 1, 8'h12); settle(1'b0);
    do_op(0, 2, 8'h05); settle(1'b0);
    check("t2_adr", last_adr, 32'h51234);
    do_op(3, 4, 8'h00);
    do_op(2, 3, 8'h00);
    settle(1'b0);
    check("t2_next_adr", last_adr, 32'h51235);

    // 3: write at top of memory, pointer wraps
    do_op(0, 0, 8'hFF); settle(1'b0);
    do_op(0, 1, 8'hFF); settle(1'b0);
    do_op(0, 2, 8'hFF); settle(1'b0);
    do_op(4, 2, 8'h00);
    do_op(1, 3, 8'hA5); settle(1'b0);
    check("t3_mem", sram_peek(32'h7FFFF), 8'hA5);
    check("t3_wrap_adr", last_adr, 0);
    for (int k = 0; k < 3; k++) do_op(4, k, 8'h00);

    // 4: mapper pre-empts a write in its second access cycle
    do_op(1, 3, 8'h3C);
    wait_en();
    check("t4_we", {31'd0, bus.sram_we}, 32'd1);
    @(posedge clk);
    #1 bus.mem_busy = 1'b1;
    #1;
    check("t4_en_drop", {31'd0, bus.sram_en}, 32'd0);
    check("t4_we_drop", {31'd0, bus.sram_we}, 32'd0);
    repeat (3) @(posedge clk);
    #1 bus.mem_busy = 1'b0;
    settle(1'b0);
    check("t4_mem", sram_peek(0), 8'h3C);
    do_op(4, 0, 8'h00);

    // 5: overrun, then simultaneous write/read strobes
    do_op(1, 3, 8'h5A);
    do_op(1, 3, 8'h77);
    do_op(3, 4, 8'h00);
    settle(1'b0);
    do_op(3, 4, 8'h00);
    check("t5_mem", sram_peek(1), 8'h5A);
    do_op(5, 3, 8'hC3);
    settle(1'b0);
    check("t5_wr_rd_mem", sram_peek(2), 8'hC3);

    // 6: reset in the middle of an access
    do_op(0, 1, 8'h99);
    wait_en();
    reset = 1'b1;
    #1;
    check("t6_en", {31'd0, bus.sram_en}, 32'd0);
    check("t6_we", {31'd0, bus.sram_we}, 32'd0);
    check("t6_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_adr", 32'(bus.sram_adr), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) do_op(4, k, 8'h00);
    do_op(3, 4, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      int kind;
      int k;
      kind = int'($urandom_range(0, 5));
      k    = (kind == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
      if (kind == 4 && (k == 3 || k == 4)) k = 5;
      do_op(kind, k, 8'($urandom));
      if (m_busy && $urandom_range(0, 2) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
          int pk;
          pk = int'($urandom_range(0, 3));
          do_op(pk, int'($urandom_range(0, 2)), 8'($urandom));
        end
      end
      settle(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sidisk_ctrl.md
Name: sidisk_ctrl

Overview:
IO-mapped RAM-disk controller for the 512K expansion SRAM. It gives the CPU byte-serial access to the whole SRAM through a small register window with an auto-incrementing address pointer. SRAM cycles are scheduled into gaps between CPU expansion-RAM memory cycles, and the CPU always has priority. It sits beside the bank-mapping logic: the mapper reports when it owns the SRAM, and this block drives the SRAM only when that is not the case.

Parameters:
ADR_W, 19, SRAM byte-address width (512K).
ACC_CYCLES, 2, clk cycles an SRAM access must hold enable uninterrupted (1..15).

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
io_sel  input  1  register window decoded by upstream IO decode (IORQ, port).
io_wr  input  1  single-cycle write strobe, qualified by io_sel.
io_rd  input  1  single-cycle read strobe, qualified by io_sel.
io_adr  input  3  register index.
io_wdata  input  8  write data.
io_rdata  output  8  read data, combinational from io_adr.
mem_busy  input  1  high while the mapper owns the SRAM for a CPU cycle.
sram_en  output  1  SRAM chip enable request, active high.
sram_we  output  1  SRAM write enable, active high, only with sram_en.
sram_adr  output  ADR_W  SRAM byte address.
sram_wdata  output  8  SRAM write data.
sram_rdata  input  8  SRAM read data.
busy  output  1  controller has an access pending or in progress.

Behaviour:
- Registers (io_adr):
  - 0: ADR_L, pointer bits 7:0.
  - 1: ADR_M, pointer bits 15:8.
  - 2: ADR_H, pointer bits ADR_W-1:16; upper bits read 0.
  - 3: DATA.
  - 4: STATUS, bit0 busy, bit1 overrun (sticky), bit2 rdbuf_valid.
  - 5-7: read 0x00, writes ignored.
- Reset values: ptr=0, rdbuf=0x00, rdbuf_valid=0, overrun=0, state IDLE, sram_en=0, sram_we=0, busy=0. sram_adr and sram_wdata = 0.
- FSM states: IDLE, WAIT_SLOT, ACCESS.
  - IDLE: on a DATA write, latch wdata, set op=WR, go to WAIT_SLOT. On an ADR_x write or a DATA read, set op=RD, go to WAIT_SLOT.
  - WAIT_SLOT: if mem_busy=0, go to ACCESS and load cnt=ACC_CYCLES-1.
  - ACCESS:
    - sram_en = !mem_busy; sram_we = (op==WR) & !mem_busy.
    - If mem_busy=1, CPU pre-empts: abort, go to WAIT_SLOT, the access restarts with a full count.
    - Otherwise, when cnt==0 the access completes; else decrement cnt.
- Access completion:
  - RD: capture sram_rdata into rdbuf on the final cycle, set rdbuf_valid, go to IDLE.
  - WR: ptr <= ptr+1, then op=RD and go to WAIT_SLOT. This prefetches the new location, so a write is always followed by a prefetch.
- Pointer rules:
  - ADR_x writes update their byte of ptr immediately and clear rdbuf_valid.
  - A DATA read returns rdbuf in the same cycle, then ptr <= ptr+1, rdbuf_valid <= 0, and a prefetch is scheduled.
  - ptr wraps modulo 2^ADR_W: 0x7FFFF+1 = 0x00000.
- sram_adr = ptr throughout; sram_wdata = latched write byte.
- busy = (state != IDLE).
- Overrun: any DATA or ADR_x access while busy is ignored and sets overrun. A STATUS read returns the current value, then clears overrun. A set and a clear in the same cycle: set wins.
- Simultaneous io_wr and io_rd: io_wr wins, the read is ignored, and io_rdata is still driven.
- Reset asserted mid-access: sram_en and sram_we drop asynchronously; no partial pointer increment survives.

Test Plan:
1. Reset, then read all registers -> 0x00 except STATUS=0x00; sram_en=0.
2. Write ADR_L=0x34, ADR_M=0x12, ADR_H=0x05, mem_busy=0 -> prefetch; sram_en high exactly ACC_CYCLES cycles at sram_adr=0x51234, sram_we=0. Then STATUS=0x04 and DATA reads the sram_rdata model value; ptr becomes 0x51235 and a new prefetch follows.
3. Pointer 0x7FFFF, write DATA=0xA5 -> SRAM model holds 0xA5 at 0x7FFFF; prefetch at 0x00000; ADR_L/M/H read 0x00.
4. Assert mem_busy during the 2nd ACCESS cycle of a write -> sram_en and sram_we drop the same cycle. Retry after mem_busy falls gives ACC_CYCLES full cycles, exactly one SRAM write, and ptr incremented once.
5. DATA write while busy=1 -> write ignored, STATUS=0x03. A second STATUS read after idle returns 0x04 (overrun cleared, valid set).
6. Assert reset during ACCESS -> outputs return to reset values immediately; ptr=0 and rdbuf_valid=0 after release.
